fifo_drain_ctrl: RTL and testbench
==================================

// Module: fifo_drain_ctrl
// PURPOSE
// - Read-side (pop) controller for the transaction-layer FIFOs: the consumer end of the push/pop interface.
// - Drains one upstream FIFO into a downstream stage, honouring that stage's almost-full back-pressure.
// - Owns the RESET/INIT/IDLE/ACTIVE state sequence.
// - Latches the almost-full/almost-empty thresholds (umbrales) during INIT and forwards them to the FIFOs.
// PARAMETERS
// - DATA_W   10  width of the FIFO data word
// - UMBRAL_W  3  width of each threshold field
// - CNT_W     8  width of the forwarded-word counter (wraps modulo 2**CNT_W)
// PORTS
// - clk                 in   1         single clock; all state on rising edge
// - reset_L             in   1         asynchronous, active-low reset
// - init                in   1         level; high requests INIT state / threshold load
// - umbral_superior_in  in   UMBRAL_W  almost-full threshold to latch in INIT
// - umbral_inferior_in  in   UMBRAL_W  almost-empty threshold to latch in INIT
// - fifo_empty          in   1         upstream FIFO empty flag
// - fifo_data           in   DATA_W    upstream FIFO read data, valid the cycle after a sampled pop
// - down_almost_full    in   1         downstream almost-full back-pressure
// - pop                 out  1         upstream FIFO read strobe
// - data_out            out  DATA_W    registered forwarded word
// - valid_out           out  1         data_out qualifier, 1-cycle pulse per word
// - umbral_superior     out  UMBRAL_W  latched almost-full threshold
// - umbral_inferior     out  UMBRAL_W  latched almost-empty threshold
// - state               out  4         one-hot state
// - fwd_count           out  CNT_W     words forwarded since reset
// - idle                out  1         1 when in IDLE and no word is in flight
// BEHAVIOUR
// - Reset (reset_L=0, async): state=4'b0001 (RESET); all other outputs 0; in-flight word discarded.
// - State encoding: RESET 4'b0001, INIT 4'b0010, IDLE 4'b0100, ACTIVE 4'b1000.
// - Transitions:
//   - RESET -> INIT on the first edge after reset_L rises.
//   - INIT -> IDLE when init=0.
//   - IDLE -> INIT if init=1; else IDLE -> ACTIVE if fifo_empty=0.
//   - ACTIVE -> INIT if init=1 (priority); else ACTIVE -> IDLE if fifo_empty=1.
// - INIT: umbral_* <= umbral_*_in on every edge while in INIT. Values hold outside INIT.
// - pop = (state==ACTIVE) & ~fifo_empty & ~down_almost_full & ~init. Combinational; no pop in RESET/INIT/IDLE.
// - Pipeline:
//   - pop sampled at edge N -> pop_q=1.
//   - At edge N+1: data_out <= fifo_data, valid_out <= 1.
//   - Latency is 2 edges from pop to valid_out. Sustained throughput is 1 word/clk.
// - valid_out=0 -> data_out holds its last value.
// - Back-pressure: pop drops in the same cycle down_almost_full rises. At most 1 popped word remains in flight and
//   is still delivered; the downstream threshold must leave >=1 slot of slack. No loss or duplication on resume.
// - An in-flight word at an INIT/IDLE transition is still delivered.
// - fwd_count increments on each valid_out pulse and wraps 2**CNT_W-1 -> 0.
// - idle = (state==IDLE) & ~pop_q & ~valid_out.
// - Simultaneous fifo_empty fall and down_almost_full rise: no pop.
// STRUCTURE
// - Shared package/header: state encodings (ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE) and DATA_W/UMBRAL_W defaults,
//   common with the FIFO and other TL controllers.
// - Single module. State register plus next-state logic, threshold latch, 1-deep pop pipeline, counter.
// - No sub-module is required.
// TESTING
// - Reset: assert reset_L=0 while ACTIVE and streaming -> state=0001, pop/valid_out/fwd_count/umbral_*=0
//   immediately (async).
// - Init: reset_L=1, init=1, umbral_in=3'b110/3'b001 -> state=0010, umbral_superior=6, umbral_inferior=1 after
//   1 edge. Then init=0 -> state=0100.
// - Drain: FIFO holds 1..9 -> pop high 9 consecutive cycles; data_out=1..9 in order with valid_out 2 edges
//   after each pop; fwd_count=9; state returns to 0100, idle=1.
// - Back-pressure: down_almost_full=1 after 3 pops -> pop=0 same cycle, exactly 3 words delivered.
//   Release -> words 4..9 follow with none lost or duplicated.
// - Init mid-stream: init=1 during ACTIVE -> pop=0 same cycle, pending word delivered, state=0010.
//   init=0 with data present -> IDLE, then ACTIVE, and draining resumes.
// - Counter wrap: forward 256 words -> fwd_count reads 255 then 0; valid_out pulse count = 256.

Source files
------------

// File: rtl/fifo_drain_ctrl_pkg.sv
// rtl/fifo_drain_ctrl_pkg.sv - shared transaction-layer FIFO controller definitions
// Purpose: one-hot state encodings and default widths shared by the TL FIFO
// and its push/pop controllers.
package fifo_drain_ctrl_pkg;

  localparam int DATA_W_DEF   = 10;
  localparam int UMBRAL_W_DEF = 3;
  localparam int CNT_W_DEF    = 8;

  // One-hot so the raw state can be exported straight onto the state port.
  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } tl_state_e;

endpackage

// File: rtl/fifo_drain_ctrl.sv
// rtl/fifo_drain_ctrl.sv - pop-side controller draining a TL FIFO downstream
// Purpose: owns the RESET/INIT/IDLE/ACTIVE sequence, latches the FIFO
// thresholds during INIT, pops the upstream FIFO while the downstream stage
// is not almost full and forwards each word through a 1-deep pipeline.
// Ports:
//   clk, reset_L            clock, asynchronous active-low reset
//   init                    level request for INIT / threshold load
//   umbral_*_in             thresholds sampled while in INIT
//   fifo_empty, fifo_data   upstream FIFO flag and read data (data valid the
//                           cycle after a sampled pop)
//   down_almost_full        downstream back-pressure
//   pop                     upstream read strobe (combinational)
//   data_out, valid_out     forwarded word and its 1-cycle qualifier
//   umbral_superior/inferior latched thresholds
//   state                   one-hot state
//   fwd_count               words forwarded since reset (wraps)
//   idle                    IDLE with nothing in flight
module fifo_drain_ctrl
  import fifo_drain_ctrl_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int UMBRAL_W = UMBRAL_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic                init,
  input  logic [UMBRAL_W-1:0] umbral_superior_in,
  input  logic [UMBRAL_W-1:0] umbral_inferior_in,
  input  logic                fifo_empty,
  input  logic [DATA_W-1:0]   fifo_data,
  input  logic                down_almost_full,
  output logic                pop,
  output logic [DATA_W-1:0]   data_out,
  output logic                valid_out,
  output logic [UMBRAL_W-1:0] umbral_superior,
  output logic [UMBRAL_W-1:0] umbral_inferior,
  output logic [3:0]          state,
  output logic [CNT_W-1:0]    fwd_count,
  output logic                idle
);

  tl_state_e state_q, state_d;
  logic      pop_q;

  // Next-state logic; init always wins over data-driven moves.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   if (!init) state_d = ST_IDLE;
      ST_IDLE: begin
        if (init)             state_d = ST_INIT;
        else if (!fifo_empty) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init)            state_d = ST_INIT;
        else if (fifo_empty) state_d = ST_IDLE;
      end
      default:   state_d = ST_RESET;
    endcase
  end

  // Gated with init and back-pressure directly so pop drops in the very
  // cycle either rises; the single word already popped is still delivered.
  assign pop = (state_q == ST_ACTIVE) & ~fifo_empty & ~down_almost_full & ~init;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q         <= ST_RESET;
      pop_q           <= 1'b0;
      valid_out       <= 1'b0;
      data_out        <= '0;
      umbral_superior <= '0;
      umbral_inferior <= '0;
      fwd_count       <= '0;
    end else begin
      state_q   <= state_d;
      // pop_q marks a word whose read data appears on fifo_data this cycle.
      pop_q     <= pop;
      valid_out <= pop_q;
      if (pop_q) begin
        data_out <= fifo_data;
      end
      if (state_q == ST_INIT) begin
        umbral_superior <= umbral_superior_in;
        umbral_inferior <= umbral_inferior_in;
      end
      if (valid_out) begin
        fwd_count <= fwd_count + 1'b1;
      end
    end
  end

  assign state = state_q;
  assign idle  = (state_q == ST_IDLE) & ~pop_q & ~valid_out;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb/tb_fifo_drain_ctrl.sv - self-checking bench for fifo_drain_ctrl
module tb_fifo_drain_ctrl;

  logic       clk = 1'b0;
  logic       reset_L = 1'b1;
  logic       init = 1'b0;
  logic [2:0] us_in = 3'd0;
  logic [2:0] ui_in = 3'd0;
  logic       fifo_empty = 1'b1;
  logic [9:0] fifo_data = 10'd0;
  logic       daf = 1'b0;
  logic       pop;
  logic [9:0] data_out;
  logic       valid_out;
  logic [2:0] umbral_superior, umbral_inferior;
  logic [3:0] state;
  logic [7:0] fwd_count;
  logic       idle;

  fifo_drain_ctrl dut (
    .clk(clk), .reset_L(reset_L), .init(init),
    .umbral_superior_in(us_in), .umbral_inferior_in(ui_in),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .down_almost_full(daf), .pop(pop), .data_out(data_out),
    .valid_out(valid_out), .umbral_superior(umbral_superior),
    .umbral_inferior(umbral_inferior), .state(state),
    .fwd_count(fwd_count), .idle(idle)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Upstream FIFO contents, words popped but not yet delivered, push request.
  int q[$];
  int inflight[$];
  int seq = 1;
  int push_n = 0;

  // Reference: state code, pop/valid pipeline flags, counter, thresholds.
  int m_state = 1;
  int m_pq = 0, m_v = 0, m_cnt = 0, m_us = 0, m_ui = 0;
  int pw;
  int pops_seen = 0, vseen = 0, wrap_seen = 0;
  int prev_cnt = 0;

  function automatic int exp_pop();
    return (m_state == 8 && !fifo_empty && !daf && !init) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      m_state = 1; m_pq = 0; m_v = 0; m_cnt = 0; m_us = 0; m_ui = 0;
      inflight.delete();
    end else begin
      int p;
      p = exp_pop();
      if (p != 0) begin
        pw = q.pop_front();
        fifo_data <= pw[9:0];
        inflight.push_back(pw);
      end
      if (m_v != 0) m_cnt = (m_cnt + 1) % 256;
      m_v  = m_pq;
      m_pq = p;
      if (m_state == 2) begin
        m_us = int'(us_in);
        m_ui = int'(ui_in);
      end
      case (m_state)
        1: m_state = 2;
        2: if (!init) m_state = 4;
        4: if (init) m_state = 2; else if (!fifo_empty) m_state = 8;
        8: if (init) m_state = 2; else if (fifo_empty) m_state = 4;
        default: m_state = 1;
      endcase
      for (int i = 0; i < push_n; i++) begin
        q.push_back(seq);
        seq = (seq + 1) % 1024;
      end
      fifo_empty <= (q.size() == 0);
    end
  end

  // One clock: check registered outputs at the falling edge, drive the new
  // inputs, then check the combinational pop against the reference.
  task automatic cyc(input int npush, input logic ini, input logic d);
    @(negedge clk);
    chk("state", state, m_state);
    chk("valid_out", valid_out, m_v);
    chk("fwd_count", fwd_count, m_cnt);
    chk("idle", idle, (m_state == 4 && m_pq == 0 && m_v == 0) ? 1 : 0);
    chk("umbral_sup", umbral_superior, m_us);
    chk("umbral_inf", umbral_inferior, m_ui);
    if (m_v != 0) begin
      chk("word_expected", (inflight.size() > 0) ? 1 : 0, 1);
      if (inflight.size() > 0) chk("data_out", data_out, inflight.pop_front());
    end
    if (valid_out) vseen++;
    if (prev_cnt == 255 && fwd_count == 8'd0) wrap_seen++;
    prev_cnt = int'(fwd_count);
    init = ini; daf = d; push_n = npush;
    #1;
    chk("pop", pop, exp_pop());
    if (pop) pops_seen++;
  endtask

  int p0, v0, g;

  initial begin
    #1 reset_L = 1'b0;
    cyc(0, 0, 0);
    chk("rst_state", state, 4'b0001);
    chk("rst_pop", pop, 0);
    chk("rst_data", data_out, 0);
    cyc(0, 0, 0);

    // Init with thresholds 6 / 1.
    reset_L = 1'b1; us_in = 3'b110; ui_in = 3'b001;
    repeat (3) cyc(0, 1, 0);
    chk("init_state", state, 4'b0010);
    chk("init_sup", umbral_superior, 6);
    chk("init_inf", umbral_inferior, 1);
    repeat (2) cyc(0, 0, 0);
    chk("idle_state", state, 4'b0100);

    // Plain drain of 1..9.
    p0 = pops_seen;
    cyc(9, 0, 0);
    repeat (20) cyc(0, 0, 0);
    chk("drain_pops", pops_seen - p0, 9);
    chk("drain_cnt", fwd_count, 9);
    chk("drain_state", state, 4'b0100);
    chk("drain_idle", idle, 1);

    // Back-pressure after 3 pops.
    p0 = pops_seen; v0 = vseen; g = 0;
    cyc(9, 0, 0);
    while (pops_seen - p0 < 3 && g < 50) begin cyc(0, 0, 0); g++; end
    chk("bp_reach3", pops_seen - p0, 3);
    repeat (6) cyc(0, 0, 1);
    chk("bp_held_words", vseen - v0, 3);
    repeat (20) cyc(0, 0, 0);
    chk("bp_total_words", vseen - v0, 9);

    // Init mid-stream.
    p0 = pops_seen; v0 = vseen; g = 0;
    cyc(6, 0, 0);
    while (pops_seen - p0 < 2 && g < 50) begin cyc(0, 0, 0); g++; end
    repeat (3) cyc(0, 1, 0);
    chk("mid_init_state", state, 4'b0010);
    repeat (20) cyc(0, 0, 0);
    chk("mid_init_words", vseen - v0, 6);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      us_in = 3'($urandom); ui_in = 3'($urandom);
      cyc(($urandom_range(0, 9) < 4) ? 1 : 0, ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0));
    end
    g = 0;
    while ((q.size() > 0 || m_v != 0 || m_pq != 0) && g < 600) begin cyc(0, 0, 0); g++; end
    chk("rand_drained", q.size(), 0);

    // Counter wrap across 256 words.
    v0 = vseen; wrap_seen = 0;
    cyc(128, 0, 0);
    cyc(128, 0, 0);
    g = 0;
    while (vseen - v0 < 256 && g < 400) begin cyc(0, 0, 0); g++; end
    repeat (3) cyc(0, 0, 0);
    chk("wrap_pulses", vseen - v0, 256);
    chk("wrap_seen", wrap_seen, 1);

    // Async reset while streaming.
    cyc(10, 0, 0);
    repeat (4) cyc(0, 0, 0);
    #2 reset_L = 1'b0;
    #1;
    chk("arst_state", state, 4'b0001);
    chk("arst_pop", pop, 0);
    chk("arst_valid", valid_out, 0);
    chk("arst_cnt", fwd_count, 0);
    chk("arst_sup", umbral_superior, 0);
    chk("arst_inf", umbral_inferior, 0);
    prev_cnt = 0;
    repeat (2) cyc(0, 0, 0);
    reset_L = 1'b1;
    repeat (3) cyc(0, 1, 0);
    g = 0;
    while ((q.size() > 0 || m_v != 0 || m_pq != 0) && g < 100) begin cyc(0, 0, 0); g++; end
    repeat (3) cyc(0, 0, 0);
    chk("arst_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
